vproc_vregfile_banked: RTL

VPROC_VREGFILE_BANKED -- requirements
Module: vproc_vregfile_banked

---
 rtl/vproc_vregfile_banked.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vproc_vregfile_banked.sv
// vproc_vregfile_banked: banked vector register file; rd_req/addr -> rd_gnt, 1-cycle rd_valid/rd_data; wr_req/addr/data/be -> wr_gnt
module vproc_vregfile_banked #(
    parameter int VREG_CNT    = 32,
    parameter int VREG_W      = 128,
    parameter int PORT_W      = 32,
    parameter int BANK_CNT    = 4,
    parameter int PORT_RD_CNT = 3,
    parameter int PORT_WR_CNT = 2,
    parameter int AW          = $clog2(VREG_CNT * VREG_W / PORT_W)
) (
    input  logic                                   clk_i,
    input  logic                                   sync_rst_i,
    input  logic [PORT_RD_CNT-1:0]                 rd_req_i,
    input  logic [PORT_RD_CNT-1:0][AW-1:0]         rd_addr_i,
    output logic [PORT_RD_CNT-1:0]                 rd_gnt_o,
    output logic [PORT_RD_CNT-1:0]                 rd_valid_o,
    output logic [PORT_RD_CNT-1:0][PORT_W-1:0]     rd_data_o,
    input  logic [PORT_WR_CNT-1:0]                 wr_req_i,
    input  logic [PORT_WR_CNT-1:0][AW-1:0]         wr_addr_i,
    input  logic [PORT_WR_CNT-1:0][PORT_W-1:0]     wr_data_i,
    input  logic [PORT_WR_CNT-1:0][PORT_W/8-1:0]   wr_be_i,
    output logic [PORT_WR_CNT-1:0]                 wr_gnt_o
);
    localparam int WORDS = VREG_CNT * VREG_W / PORT_W;
    localparam int BB    = $clog2(BANK_CNT);
    localparam int BW    = BB > 0 ? BB : 1;
    localparam int ROWS  = WORDS / BANK_CNT;
    localparam int RW    = AW - BB > 0 ? AW - BB : 1;
    localparam int PW    = PORT_RD_CNT > 1 ? $clog2(PORT_RD_CNT) : 1;
    localparam int QW    = PORT_WR_CNT > 1 ? $clog2(PORT_WR_CNT) : 1;
    localparam int NBY   = PORT_W / 8;
    logic [PORT_RD_CNT-1:0][BW-1:0]     rd_bank;
    logic [PORT_RD_CNT-1:0][RW-1:0]     rd_row;
    logic [PORT_RD_CNT-1:0]             rd_inr;
    logic [PORT_WR_CNT-1:0][BW-1:0]     wr_bank;
    logic [PORT_WR_CNT-1:0][RW-1:0]     wr_row;
    logic [PORT_WR_CNT-1:0]             wr_inr;
    logic [BANK_CNT-1:0][PW-1:0]        rr_q, rd_win;
    logic [BANK_CNT-1:0]                rd_any, wr_any, wr_en;
    logic [BANK_CNT-1:0][QW-1:0]        wr_win;
    logic [BANK_CNT-1:0][RW-1:0]        wr_row_b;
    logic [BANK_CNT-1:0][PORT_W-1:0]    wr_dat_b;
    logic [BANK_CNT-1:0][NBY-1:0]       wr_be_b;
    logic [PORT_RD_CNT-1:0][PORT_W-1:0] rd_word, rd_data_q;
    logic [PORT_RD_CNT-1:0]             rd_valid_q;
    logic [PORT_W-1:0]                  mem [BANK_CNT][ROWS];
    always_comb begin
        for (int p = 0; p < PORT_RD_CNT; p++) begin
            rd_bank[p] = BW'(rd_addr_i[p] & AW'(BANK_CNT - 1));
            rd_row[p]  = RW'(rd_addr_i[p] >> BB);
            rd_inr[p]  = int'(rd_addr_i[p]) < WORDS;
        end
        for (int p = 0; p < PORT_WR_CNT; p++) begin
            wr_bank[p] = BW'(wr_addr_i[p] & AW'(BANK_CNT - 1));
            wr_row[p]  = RW'(wr_addr_i[p] >> BB);
            wr_inr[p]  = int'(wr_addr_i[p]) < WORDS;
        end
    end
    // Descending scans leave the lowest matching index; the second read pass
    // overrides with the lowest requester at or above the round-robin pointer.
    always_comb begin
        rd_any = '0;
        rd_win = '0;
        wr_any = '0;
        wr_win = '0;
        for (int b = 0; b < BANK_CNT; b++) begin
            for (int p = PORT_RD_CNT - 1; p >= 0; p--)
                if (rd_req_i[p] && int'(rd_bank[p]) == b) begin
                    rd_any[b] = 1'b1;
                    rd_win[b] = PW'(p);
                end
            for (int p = PORT_RD_CNT - 1; p >= 0; p--)
                if (rd_req_i[p] && int'(rd_bank[p]) == b && p >= int'(rr_q[b]))
                    rd_win[b] = PW'(p);
            for (int p = PORT_WR_CNT - 1; p >= 0; p--)
                if (wr_req_i[p] && int'(wr_bank[p]) == b) begin
                    wr_any[b] = 1'b1;
                    wr_win[b] = QW'(p);
                end
        end
    end
    always_comb begin
        wr_en    = '0;
        wr_row_b = '0;
        wr_dat_b = '0;
        wr_be_b  = '0;
        rd_gnt_o = '0;
        wr_gnt_o = '0;
        rd_word  = '0;
        for (int b = 0; b < BANK_CNT; b++) begin
            wr_en[b]    = wr_any[b] && !sync_rst_i && wr_inr[wr_win[b]];
            wr_row_b[b] = wr_row[wr_win[b]];
            wr_dat_b[b] = wr_data_i[wr_win[b]];
            wr_be_b[b]  = wr_be_i[wr_win[b]];
        end
        for (int p = 0; p < PORT_WR_CNT; p++)
            wr_gnt_o[p] = !sync_rst_i && wr_req_i[p] && wr_win[wr_bank[p]] == QW'(p);
        for (int p = 0; p < PORT_RD_CNT; p++) begin
            rd_gnt_o[p] = !sync_rst_i && rd_req_i[p] && rd_win[rd_bank[p]] == PW'(p);
            rd_word[p]  = mem[rd_bank[p]][rd_row[p]];
            // same bank and row means same word: merge the write's enabled bytes
            for (int j = 0; j < NBY; j++)
                if (wr_en[rd_bank[p]] && wr_row_b[rd_bank[p]] == rd_row[p] && wr_be_b[rd_bank[p]][j])
                    rd_word[p][j*8 +: 8] = wr_dat_b[rd_bank[p]][j*8 +: 8];
            rd_word[p] = rd_inr[p] ? rd_word[p] : '0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            rr_q       <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_gnt_o;
            for (int p = 0; p < PORT_RD_CNT; p++)
                if (rd_gnt_o[p]) rd_data_q[p] <= rd_word[p];
            for (int b = 0; b < BANK_CNT; b++)
                if (rd_any[b]) rr_q[b] <= int'(rd_win[b]) == PORT_RD_CNT - 1 ? '0 : rd_win[b] + 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BANK_CNT; b++)
            for (int j = 0; j < NBY; j++)
                if (wr_en[b] && wr_be_b[b][j]) mem[b][wr_row_b[b]][j*8 +: 8] <= wr_dat_b[b][j*8 +: 8];
    end
    // a read granted just before reset must not surface while reset is held
    assign rd_valid_o = sync_rst_i ? '0 : rd_valid_q;
    assign rd_data_o  = sync_rst_i ? '0 : rd_data_q;
endmodule
